// File: rtl/noc_output_scheduler.sv
// noc_output_scheduler: round-robin arbiter feeding a one-flit registered output stage with a saturating contention counter
module noc_output_scheduler #(
    parameter int NUM_IN = 5,
    parameter int WIDTH  = 11,
    parameter int SELW   = $clog2(NUM_IN),
    parameter int CNTW   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SELW-1:0]         out_sel,
    input  logic                    out_ready,
    output logic [CNTW-1:0]         contention_cnt
);
    localparam logic [SELW:0]   N_EXT = (SELW+1)'(NUM_IN);
    localparam logic [SELW-1:0] LAST  = SELW'(NUM_IN - 1);

    logic [SELW-1:0]     r_ptr;
    logic                r_valid;
    logic [WIDTH-1:0]    r_data;
    logic [SELW-1:0]     r_sel;
    logic [CNTW-1:0]     r_cnt;
    logic [2*NUM_IN-1:0] w_dbl;
    logic [NUM_IN-1:0]   w_rot;
    logic [SELW-1:0]     w_off;
    logic [SELW:0]       w_sum;
    logic [SELW-1:0]     w_win;
    logic [SELW-1:0]     w_nxt;
    logic                w_grant;
    logic                w_multi;

    assign w_dbl   = {in_valid, in_valid} >> r_ptr;
    assign w_rot   = w_dbl[NUM_IN-1:0];
    assign w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
    assign w_win   = (w_sum >= N_EXT) ? SELW'(w_sum - N_EXT) : SELW'(w_sum);
    assign w_nxt   = (w_win == LAST) ? '0 : w_win + 1'b1;
    assign w_grant = (!r_valid || out_ready) && |in_valid && !reset;
    assign w_multi = |(in_valid & (in_valid - 1'b1));
    assign in_ready       = w_grant ? (NUM_IN'(1) << w_win) : '0;
    assign out_valid      = r_valid;
    assign out_data       = r_data;
    assign out_sel        = r_sel;
    assign contention_cnt = r_cnt;

    // Distance from ptr to the first valid requester in the rotated request vector.
    always_comb begin
        w_off = '0;
        for (int k = NUM_IN - 1; k >= 0; k--)
            if (w_rot[k]) w_off = SELW'(k);
    end

    // Output register load/drain, pointer advance on grant, saturating contention count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_grant) begin
                r_valid <= 1'b1;
                r_data  <= in_data[w_win*WIDTH +: WIDTH];
                r_sel   <= w_win;
                r_ptr   <= w_nxt;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_grant && w_multi && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: doc/noc_output_scheduler.md
Name: noc_output_scheduler

Overview:
- Clocked round-robin scheduler sharing one router output link among NUM_IN requesters: 4 neighbour ports plus the local core.
- Selects one flit per cycle, registers it in a one-entry output stage, and reports the winning source index for the downstream merge stage.
- Counts contention cycles for performance monitoring.
- Sits between the router input buffers and the output merge/link.

Parameters:
- NUM_IN, 5, number of requesters; index NUM_IN-1 is the core port.
- WIDTH, 11, flit width in bits.
- SELW, $clog2(NUM_IN), width of the source-index fields.
- CNTW, 16, width of the contention counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  NUM_IN  per-requester flit-present flag.
- in_data  input  NUM_IN*WIDTH  packed flits; requester i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_IN  one-hot (or zero) accept strobe back to requesters.
- out_valid  output  1  output register holds a flit.
- out_data  output  WIDTH  registered flit.
- out_sel  output  SELW  registered source index of out_data.
- out_ready  input  1  downstream accepts out_data this cycle.
- contention_cnt  output  CNTW  saturating count of cycles with ≥2 requesters valid while a grant was issued.

Behaviour:
- Reset (synchronous, active-high): the following values are visible after the first clk edge with reset=1.
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - contention_cnt=0.
  - in_ready=0 combinationally while reset is high.
- can_load = !out_valid || out_ready (combinational).
- Winner: the first i with in_valid[i]=1, searching ptr, ptr+1, … NUM_IN-1, 0, …, ptr-1 (modulo NUM_IN).
- Grant condition: can_load && |in_valid && !reset.
  - On grant, in_ready is one-hot on the winner in the same cycle; otherwise in_ready=0.
  - in_ready never asserts for a requester whose in_valid=0.
- Transfer rule: a flit is consumed when in_valid[i] && in_ready[i] at a clk edge.
  - On that edge: out_data <= in_data[winner], out_sel <= winner, out_valid <= 1, ptr <= (winner+1) mod NUM_IN.
  - Latency: input handshake to out_valid=1 is 1 cycle.
- Output drain:
  - out_valid && out_ready with no new grant: out_valid <= 0 next edge.
  - Drain and grant in the same cycle: out_valid stays 1 and the register is replaced. Sustained throughput is 1 flit/cycle.
- Backpressure: while out_valid && !out_ready, out_data and out_sel hold stable, in_ready=0, and ptr is unchanged.
- ptr changes only on a grant. A cycle with no requests leaves ptr unchanged.
- Single requester: always granted when can_load, regardless of ptr.
- Fairness: with all NUM_IN requesters continuously valid and out_ready=1, grants cycle 0,1,…,NUM_IN-1,0,… and every requester is served within NUM_IN grants.
- contention_cnt: increments by 1 on each grant cycle where popcount(in_valid) ≥ 2; saturates at 2^CNTW-1 (no wrap).
- Reset mid-operation: any held flit is dropped (out_valid=0), and no handshake completes in the reset cycle.
- No combinational path from out_ready to out_data. Paths out_ready→in_ready and in_valid→in_ready are permitted.

Test Plan:
1. Reset: hold reset 2 cycles with in_valid=5'b11111 and out_ready=1 → in_ready=0 throughout; after release out_valid=0, contention_cnt=0. First grant goes to index 0 (out_sel=0 one cycle later).
2. Round-robin: all five valid with distinct data 11'h0A0+i, out_ready=1, 10 cycles → out_sel sequence 0,1,2,3,4,0,1,2,3,4 on consecutive cycles with matching data; contention_cnt=10.
3. Single requester: only in_valid[3]=1 with data 11'h155, out_ready=1 → in_ready=5'b01000 every cycle, out_sel=3, out_data=11'h155, back-to-back, contention_cnt stays 0.
4. Backpressure: one flit captured, then out_ready=0 for 4 cycles with requesters 1 and 2 valid → out_data and out_sel stable, in_ready=0, ptr unchanged. When out_ready=1, the next winner follows the pre-stall ptr.
5. Pointer skip: ptr=2 (after granting 1); only requesters 0 and 4 valid → grant 4, then 0; ptr ends at 1.
6. Saturation and reset: force contention for 2^CNTW+3 cycles (CNTW=4 instance: 19 cycles) → contention_cnt holds 15. Then assert reset one cycle while out_valid=1 → out_valid=0 and contention_cnt=0 on the next edge.
